// File: rtl/vid_timing_rx_if.sv
// ---------------------------------------------------------------------------
// vid_timing_rx_if
//   Incoming video bus for the timing receiver.
//   vsync_i  : high across the active-line window of a frame
//   hsync_i  : rising edge marks the start of a line
//   dval_i   : pixel valid
//   rdata_i / gdata_i / bdata_i : RGB888 pixel components
//   master : video source (drives the bus)
//   slave  : video sink (samples the bus)
// ---------------------------------------------------------------------------
interface vid_timing_rx_if;
    logic       vsync_i;
    logic       hsync_i;
    logic       dval_i;
    logic [7:0] rdata_i;
    logic [7:0] gdata_i;
    logic [7:0] bdata_i;

    modport master (
        output vsync_i, hsync_i, dval_i, rdata_i, gdata_i, bdata_i
    );

    modport slave (
        input vsync_i, hsync_i, dval_i, rdata_i, gdata_i, bdata_i
    );
endinterface

// File: rtl/vid_timing_rx.sv
// ---------------------------------------------------------------------------
// vid_timing_rx
//   Video timing receiver / checker in the pixel clock domain. Re-times the
//   incoming pixels with one cycle of latency, tags them with x/y and
//   start-of-frame, measures active geometry per frame and declares lock
//   after LOCK_FRAMES consecutive frames of the expected geometry.
//
//   px_clk, sys_rst     : clock, asynchronous active-high reset
//   vid (slave)         : vsync/hsync/dval/RGB888 input bus
//   pix_valid_o, [rgb]data_o, x_o, y_o, sof_o : re-timed pixel stream
//   line_err_o, frame_err_o : one-cycle error pulses
//   locked_o            : geometry lock status
//   meas_hact_o, meas_vact_o : measured geometry of last completed frame
//   frame_cnt_o, err_cnt_o   : completed frames (wraps), frame errors (sat)
// ---------------------------------------------------------------------------
module vid_timing_rx #(
    parameter int unsigned HACT_EXP    = 640,
    parameter int unsigned VACT_EXP    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                px_clk,
    input  logic                sys_rst,
    vid_timing_rx_if.slave      vid,
    output logic                pix_valid_o,
    output logic [7:0]          rdata_o,
    output logic [7:0]          gdata_o,
    output logic [7:0]          bdata_o,
    output logic [11:0]         x_o,
    output logic [11:0]         y_o,
    output logic                sof_o,
    output logic                line_err_o,
    output logic                frame_err_o,
    output logic                locked_o,
    output logic [11:0]         meas_hact_o,
    output logic [11:0]         meas_vact_o,
    output logic [15:0]         frame_cnt_o,
    output logic [7:0]          err_cnt_o
);

    localparam logic [11:0] HACT_W = 12'(HACT_EXP);
    localparam logic [11:0] VACT_W = 12'(VACT_EXP);
    localparam logic [4:0]  LOCK_W = 5'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_LOCKED} state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        active_q, active_d;
    logic        sof_arm_q, sof_arm_d;
    logic        bad_q, bad_d;
    logic [11:0] pcnt_q, pcnt_d;
    logic [11:0] lcnt_q, lcnt_d;
    logic [11:0] last_q, last_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic        pix_valid_q, pix_valid_d;
    logic [7:0]  rdata_q, rdata_d, gdata_q, gdata_d, bdata_q, bdata_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        sof_q, sof_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        locked_q, locked_d;
    logic [11:0] meas_hact_q, meas_hact_d, meas_vact_q, meas_vact_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        hs_rise, vs_rise, vs_fall;
    logic        frame_end, close_ev, pix, frame_good;
    logic [4:0]  gcnt_inc;

    always_comb begin
        hs_rise   = vid.hsync_i & ~hsync_q;
        vs_rise   = vid.vsync_i & ~vsync_q;
        vs_fall   = ~vid.vsync_i & vsync_q;
        // A fall only ends a frame that was actually opened by a rise.
        frame_end = vs_fall & active_q;
        close_ev  = active_q & (hs_rise | vs_fall) & (pcnt_q != 12'd0);
        pix       = vid.vsync_i & (active_q | vs_rise) & vid.dval_i;
        gcnt_inc  = {1'b0, gcnt_q} + 5'd1;

        hsync_d     = vid.hsync_i;
        vsync_d     = vid.vsync_i;
        active_d    = active_q;
        sof_arm_d   = sof_arm_q;
        bad_d       = bad_q;
        pcnt_d      = pcnt_q;
        lcnt_d      = lcnt_q;
        last_d      = last_q;
        gcnt_d      = gcnt_q;
        state_d     = state_q;
        pix_valid_d = pix;
        rdata_d     = vid.rdata_i;
        gdata_d     = vid.gdata_i;
        bdata_d     = vid.bdata_i;
        x_d         = x_q;
        y_d         = y_q;
        sof_d       = 1'b0;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;
        meas_hact_d = meas_hact_q;
        meas_vact_d = meas_vact_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        frame_good  = 1'b0;

        if (vs_rise) begin
            active_d  = 1'b1;
            pcnt_d    = 12'd0;
            lcnt_d    = 12'd0;
            bad_d     = 1'b0;
            sof_arm_d = 1'b1;
        end else if (vs_fall) begin
            active_d = 1'b0;
        end

        // Close the running line first so a pixel in the hs_rise cycle
        // becomes pixel 0 of the new line.
        if (close_ev) begin
            lcnt_d = sat_inc12(lcnt_q);
            last_d = pcnt_q;
            pcnt_d = 12'd0;
            if (pcnt_q != HACT_W) begin
                line_err_d = 1'b1;
                bad_d      = 1'b1;
            end
        end

        if (pix) begin
            x_d       = pcnt_d;
            y_d       = lcnt_d;
            sof_d     = sof_arm_d;
            sof_arm_d = 1'b0;
            pcnt_d    = sat_inc12(pcnt_d);
        end

        if (frame_end) begin
            meas_vact_d = lcnt_d;
            meas_hact_d = last_d;
            frame_cnt_d = frame_cnt_q + 16'd1;
            frame_good  = (lcnt_d == VACT_W) && !bad_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    state_d = ST_HUNT;
                    gcnt_d  = 4'd0;
                end
            end
            ST_HUNT: begin
                if (frame_end) begin
                    if (frame_good) begin
                        gcnt_d = gcnt_inc[3:0];
                        if (gcnt_inc >= LOCK_W) state_d = ST_LOCKED;
                    end else begin
                        gcnt_d      = 4'd0;
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame_end && !frame_good) begin
                    state_d     = ST_HUNT;
                    gcnt_d      = 4'd0;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        locked_d = (state_d == ST_LOCKED);
        if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Stage boundary: all state and the re-timed pixel stream.
    always_ff @(posedge px_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            active_q    <= 1'b0;
            sof_arm_q   <= 1'b0;
            bad_q       <= 1'b0;
            pcnt_q      <= '0;
            lcnt_q      <= '0;
            last_q      <= '0;
            gcnt_q      <= '0;
            pix_valid_q <= 1'b0;
            rdata_q     <= '0;
            gdata_q     <= '0;
            bdata_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sof_q       <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
            meas_hact_q <= '0;
            meas_vact_q <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
            sof_arm_q   <= sof_arm_d;
            bad_q       <= bad_d;
            pcnt_q      <= pcnt_d;
            lcnt_q      <= lcnt_d;
            last_q      <= last_d;
            gcnt_q      <= gcnt_d;
            pix_valid_q <= pix_valid_d;
            rdata_q     <= rdata_d;
            gdata_q     <= gdata_d;
            bdata_q     <= bdata_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sof_q       <= sof_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
            meas_hact_q <= meas_hact_d;
            meas_vact_q <= meas_vact_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign rdata_o     = rdata_q;
    assign gdata_o     = gdata_q;
    assign bdata_o     = bdata_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign sof_o       = sof_q;
    assign line_err_o  = line_err_q;
    assign frame_err_o = frame_err_q;
    assign locked_o    = locked_q;
    assign meas_hact_o = meas_hact_q;
    assign meas_vact_o = meas_vact_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_vid_timing_rx.sv
// ---------------------------------------------------------------------------
// tb_vid_timing_rx
//   Directed bench for vid_timing_rx with an 8x4 geometry and lock after two
//   good frames. Inputs change 1 ns after the rising edge; outputs are read
//   at the same point, reflecting the inputs sampled at that edge.
// ---------------------------------------------------------------------------
module tb_vid_timing_rx;

    logic        px_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        pix_valid_o, sof_o, line_err_o, frame_err_o, locked_o;
    logic [7:0]  rdata_o, gdata_o, bdata_o, err_cnt_o;
    logic [11:0] x_o, y_o, meas_hact_o, meas_vact_o;
    logic [15:0] frame_cnt_o;
    int          total = 0;
    int          bad = 0;

    vid_timing_rx_if vif();

    vid_timing_rx #(.HACT_EXP(8), .VACT_EXP(4), .LOCK_FRAMES(2)) dut (
        .px_clk      (px_clk),
        .sys_rst     (sys_rst),
        .vid         (vif.slave),
        .pix_valid_o (pix_valid_o),
        .rdata_o     (rdata_o),
        .gdata_o     (gdata_o),
        .bdata_o     (bdata_o),
        .x_o         (x_o),
        .y_o         (y_o),
        .sof_o       (sof_o),
        .line_err_o  (line_err_o),
        .frame_err_o (frame_err_o),
        .locked_o    (locked_o),
        .meas_hact_o (meas_hact_o),
        .meas_vact_o (meas_vact_o),
        .frame_cnt_o (frame_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 px_clk = ~px_clk;

    function automatic logic [127:0] all_out();
        return {27'd0, pix_valid_o, rdata_o, gdata_o, bdata_o, x_o, y_o, sof_o,
                line_err_o, frame_err_o, locked_o, meas_hact_o, meas_vact_o,
                frame_cnt_o, err_cnt_o};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic rand_in();
        vif.vsync_i = 1'($urandom);
        vif.hsync_i = 1'($urandom);
        vif.dval_i  = 1'($urandom);
        vif.rdata_i = 8'($urandom);
        vif.gdata_i = 8'($urandom);
        vif.bdata_i = 8'($urandom);
    endtask

    task automatic vs_up();
        vif.vsync_i = 1'b1;
        vif.hsync_i = 1'b0;
        vif.dval_i  = 1'b0;
        tick();
    endtask

    // One line: hs_rise cycle (closes the previous line), n pixels, blank.
    task automatic line(input int n, input int y, input bit prev_err);
        vif.hsync_i = 1'b1;
        vif.dval_i  = 1'b0;
        tick();
        chk("line_err_at_hs", line_err_o, prev_err);
        vif.hsync_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            vif.dval_i  = 1'b1;
            vif.rdata_i = 8'($urandom);
            vif.gdata_i = 8'($urandom);
            vif.bdata_i = 8'($urandom);
            tick();
            chk("pix_valid", pix_valid_o, 1);
            chk("x", x_o, i);
            chk("y", y_o, y);
            chk("sof", sof_o, (i == 0 && y == 0));
            chk("rgb", {rdata_o, gdata_o, bdata_o}, {vif.rdata_i, vif.gdata_i, vif.bdata_i});
        end
        vif.dval_i = 1'b0;
        tick();
        chk("pix_valid_blank", pix_valid_o, 0);
    endtask

    task automatic vs_down(input bit hs, input bit ferr, input bit lock,
                           input int vact, input int fcnt, input int ecnt);
        vif.vsync_i = 1'b0;
        vif.hsync_i = hs;
        vif.dval_i  = 1'b0;
        tick();
        chk("line_err_at_vs", line_err_o, 0);
        chk("frame_err", frame_err_o, ferr);
        chk("locked", locked_o, lock);
        chk("meas_vact", meas_vact_o, vact);
        chk("meas_hact", meas_hact_o, 8);
        chk("frame_cnt", frame_cnt_o, fcnt);
        chk("err_cnt", err_cnt_o, ecnt);
        vif.hsync_i = 1'b0;
        tick();
        chk("frame_err_pulse_end", frame_err_o, 0);
        chk("locked_hold", locked_o, lock);
        tick();
    endtask

    task automatic clean_frame(input bit lock, input int fcnt, input int ecnt);
        vs_up();
        for (int l = 0; l < 4; l++) line(8, l, 0);
        vs_down(0, 0, lock, 4, fcnt, ecnt);
    endtask

    initial begin
        vif.vsync_i = 1'b0;
        vif.hsync_i = 1'b0;
        vif.dval_i  = 1'b0;
        vif.rdata_i = 8'd0;
        vif.gdata_i = 8'd0;
        vif.bdata_i = 8'd0;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            rand_in();
            tick();
            chk("reset_outputs", all_out(), 0);
        end
        vif.vsync_i = 1'b0;
        vif.hsync_i = 1'b0;
        vif.dval_i  = 1'b0;
        sys_rst = 1'b0;
        tick();
        tick();
        chk("idle_after_release", all_out() & 128'h1, 0);
        chk("locked_after_release", locked_o, 0);

        // Two clean frames -> lock.
        clean_frame(0, 1, 0);
        clean_frame(1, 2, 0);

        // Locked, line 2 short.
        vs_up();
        line(8, 0, 0);
        line(8, 1, 0);
        line(7, 2, 0);
        line(8, 3, 1);
        vs_down(0, 1, 0, 4, 3, 1);

        // Relock.
        clean_frame(0, 4, 1);
        clean_frame(1, 5, 1);

        // Five lines.
        vs_up();
        for (int l = 0; l < 5; l++) line(8, l, 0);
        vs_down(0, 1, 0, 5, 6, 2);

        // Last line closed by hs_rise coincident with vs_fall.
        vs_up();
        for (int l = 0; l < 4; l++) line(8, l, 0);
        vs_down(1, 0, 0, 4, 7, 2);
        clean_frame(1, 8, 2);

        // Async reset mid-frame, away from the clock edge.
        vs_up();
        line(8, 0, 0);
        vif.hsync_i = 1'b1;
        vif.dval_i  = 1'b1;
        tick();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("async_reset", all_out(), 0);
        for (int i = 0; i < 3; i++) begin
            rand_in();
            tick();
            chk("reset_hold", all_out(), 0);
        end

        // vsync already high at release: partial frame checked normally.
        vif.vsync_i = 1'b1;
        vif.hsync_i = 1'b0;
        vif.dval_i  = 1'b0;
        sys_rst = 1'b0;
        tick();
        for (int l = 0; l < 4; l++) line(8, l, 0);
        vs_down(0, 0, 0, 4, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vid_timing_rx.md
# vid_timing_rx

Video timing receiver and checker for the px_clk domain; the sink-side counterpart of the team's test-pattern/VGA timing generator. It consumes vsync/hsync/dval/RGB888 and re-times the pixels with 1-cycle latency, tagged with x/y coordinates and start-of-frame. It measures active geometry per frame and declares lock after consecutive frames match the expected geometry, flagging line and frame errors. It sits at the input of any downstream pixel consumer (capture, overlay, checker) and in benches as the monitor for generated video.

## Interface
- HACT_EXP, 640, expected dval cycles per active line
- VACT_EXP, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert lock (1..15)
- px_clk  in  1  pixel clock; all logic on its rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- vsync_i  in  1  high for the whole active-line window of a frame
- hsync_i  in  1  rising edge marks start of a line
- dval_i  in  1  pixel valid
- rdata_i / gdata_i / bdata_i  in  8 each  pixel components
- pix_valid_o  out  1  registered dval_i, qualified by frame active
- rdata_o / gdata_o / bdata_o  out  8 each  registered pixel data
- x_o  out  12  pixel index within line for the current output pixel
- y_o  out  12  line index within frame for the current output pixel
- sof_o  out  1  high with the first output pixel of a frame (x_o=0, y_o=0)
- line_err_o  out  1  1-cycle pulse: closed line had pixel count != HACT_EXP
- frame_err_o  out  1  1-cycle pulse: completed frame failed geometry check
- locked_o  out  1  geometry lock status
- meas_hact_o  out  12  pixel count of last closed line of last completed frame
- meas_vact_o  out  12  line count of last completed frame
- frame_cnt_o  out  16  completed frames, wraps
- err_cnt_o  out  8  frame_err events, saturates at 255

## Operation
- Edges: hsync_q/vsync_q hold previous-cycle inputs; hs_rise = hsync_i & ~hsync_q; vs_rise = vsync_i & ~vsync_q; vs_fall = ~vsync_i & vsync_q.
- Frame active flag: set on vs_rise, cleared on vs_fall. vs_rise clears line counter, pcnt, frame-bad flag, and arms sof.
- pcnt counts dval_i cycles within the line (saturates 4095). Line close: on hs_rise or vs_fall, if pcnt > 0 -> line counter +1 (saturates 4095), line_err_o if pcnt != HACT_EXP, set frame-bad on error, latch pcnt as last-line count, clear pcnt. Lines with pcnt=0 are ignored (blanking). hs_rise and vs_fall in the same cycle close the line exactly once.
- Pixel with dval_i in the hs_rise cycle is pixel 0 of the new line (close first, then count).
- x_o = pcnt value before increment; y_o = lines closed so far in the frame. Pixels outside frame active: pix_valid_o=0, counters untouched.
- Frame end (vs_fall): meas_vact_o <= line count (incl. line closed this cycle), meas_hact_o <= last-line count, frame_cnt_o +1; frame good = line count == VACT_EXP and no line error.
- FSM: IDLE -> HUNT on first vs_rise. HUNT at frame end: good -> gcnt+1, gcnt reaching LOCK_FRAMES -> LOCKED, locked_o=1; bad -> gcnt=0, frame_err_o pulse. LOCKED at frame end: good -> stay; bad -> HUNT, gcnt=0, locked_o=0, frame_err_o pulse. err_cnt_o +1 per frame_err_o.
- vs_fall without preceding vs_rise (after reset) is ignored.

## Timing
- Reset: every output 0, FSM IDLE, edge registers 0. vsync_i already high at release gives a vs_rise in the first cycle; that partial frame is checked normally.
- Pixel path latency 1: inputs sampled at edge N appear on outputs after edge N, with x_o/y_o/sof_o aligned.
- line_err_o, frame_err_o, meas_*, frame_cnt_o, locked_o update at the edge sampling the closing hs_rise/vs_fall; pulses last exactly one cycle.
- No back-pressure; one pixel per clock sustained.

## Test plan
- Reset held, random inputs -> all outputs 0, locked_o=0; async assert mid-frame -> outputs 0 without a clock edge.
- HACT_EXP=8, VACT_EXP=4, two clean frames -> locked_o=1 the cycle after 2nd vs_fall sample; meas_hact_o=8, meas_vact_o=4, frame_cnt_o=2, err_cnt_o=0.
- Coordinate check in clean frame -> first pixel sof_o=1 x=0 y=0; last pixel x=7 y=3; data equals input delayed 1 cycle.
- Locked, line 2 carries 7 pixels -> line_err_o at its closing hs_rise, frame_err_o at vs_fall, locked_o=0, err_cnt_o=1, meas_hact_o=8; two clean frames -> relock.
- Frame with 5 lines -> frame_err_o, meas_vact_o=5, no line_err_o.
- Last line closed by hs_rise coincident with vs_fall -> meas_vact_o=4, single close, no error.
